bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Round-robin arbiter for the shared 32-bit CPU bus. Chooses one of N_REQ bus drivers
//  (registers R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_ext, ...).
//  Outputs a registered one-hot grant, its 5-bit encoded select for the bus mux, and a valid flag.
//  The owner holds the bus until it signals done, drops its request, or hits the hold limit.
// PARAMETERS
//  N_REQ     32  number of requesters; exactly one grant bit per requester
//  SEL_W     5   select width; must satisfy 2**SEL_W >= N_REQ
//  MAX_HOLD  16  max consecutive OWN cycles before forced release; legal range 2..255
// PORTS
//  clk          in   1      rising-edge clock; the only clock
//  clr          in   1      synchronous active-high reset, sampled on rising clk
//  req          in   N_REQ  request vector, bit i = requester i
//  done         in   1      owner finished; sampled in OWN only
//  grant        out  N_REQ  registered one-hot grant, or all zero
//  sel          out  SEL_W  binary index of the set grant bit; 0 when grant == 0
//  grant_valid  out  1      high exactly when grant != 0
//  timeout      out  1      one-cycle pulse on a forced release
// BEHAVIOUR
//  Reset (clr=1 at an edge): state=IDLE, grant=0, sel=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0.
//   clr has priority over every other input.
//   If clr arrives mid-ownership, grant drops at that same edge; no timeout pulse.
//  States:
//   IDLE: if |req, pick the first set req bit scanning ptr, ptr+1, ... wrapping N_REQ-1 -> 0.
//    Register grant/sel/grant_valid for the winner; hold_cnt=0; go to OWN.
//    If no req, stay in IDLE with outputs 0.
//    Latency: req high at edge k -> grant visible after edge k.
//   OWN: grant, sel and grant_valid are held stable. hold_cnt increments every cycle. Exit to IDLE when:
//    (a) done=1, or (b) req[owner]=0, or (c) hold_cnt == MAX_HOLD-1.
//   On exit: grant=0, sel=0, grant_valid=0, ptr = (owner+1) mod N_REQ.
//   Timeout: pulses high for one cycle only for exit (c) when (a) and (b) are both false.
//    If done or the request drop coincides with the limit, it is a normal release with no pulse.
//  Turnaround: at least one IDLE cycle with grant == 0 between consecutive owners, so the bus never has two drivers.
//  Fairness: a continuous requester is re-granted only after every other active requester has been served once.
//  Requests from non-owners during OWN are ignored; there is no preemption.
//  sel always equals the binary index of grant; sel=0 with grant_valid=0 means no driver.
//  ptr width is SEL_W and wraps modulo N_REQ. hold_cnt is 8 bits and never exceeds MAX_HOLD-1.
//  Invariant: popcount(grant) <= 1 in every cycle.
// STRUCTURE
//  Shared package bus_pkg holds:
//   N_REQ, SEL_W and MAX_HOLD defaults
//   state encoding: localparam ST_IDLE=1'b0, ST_OWN=1'b1
//   named requester indices (e.g. REQ_PC=20, REQ_MDR=21)
//  One sub-module: rr_pick (combinational).
//   Inputs: req and ptr. Outputs: one-hot winner, its binary index, and any-flag.
//   Implement by rotate by ptr, fixed-priority LSB-first, rotate back.
//  The top module holds the FSM, ptr, hold_cnt and the output registers.
// TESTING
//  1 Reset: hold clr for 2 cycles with req=32'hFFFFFFFF.
//    -> grant=0, sel=0, grant_valid=0, timeout=0.
//    After release -> grant=32'h1, sel=0, grant_valid=1.
//  2 Rotation: req=32'h0010_0202 held; pulse done in each owner's 2nd OWN cycle.
//    -> sel goes 1, 9, 20, 1.
//    Exactly one grant==0 cycle between owners.
//  3 Wrap: ptr=31 (after serving bit 30), req=32'h8000_0001.
//    -> sel=31 first, then sel=0.
//  4 Timeout: req=32'h8 held, done=0.
//    -> grant=32'h8 for exactly 16 cycles, then one cycle with timeout=1 and grant=0, then re-grant to sel=3.
//  5 Coincidence: done asserted on the 16th OWN cycle.
//    -> release with timeout=0.
//    Separately, requester drops req mid-OWN -> release on the next edge.
//  6 Mid-op reset: clr in the 5th OWN cycle.
//    -> grant=0 at that edge, timeout=0.
//    Next grant goes to the lowest set req bit (ptr=0).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus arbiter: size defaults, FSM encoding
// and the fixed bus-driver slot numbers.
package bus_pkg;

  localparam int N_REQ_DEF    = 32;
  localparam int SEL_W_DEF    = 5;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Slots 0-15 are the general registers R0-R15.
  localparam int REQ_HI         = 16;
  localparam int REQ_LO         = 17;
  localparam int REQ_ZHIGH      = 18;
  localparam int REQ_ZLOW       = 19;
  localparam int REQ_PC         = 20;
  localparam int REQ_MDR        = 21;
  localparam int REQ_INPORT     = 22;
  localparam int REQ_C_SIGN_EXT = 23;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus drivers (master) and the arbiter (slave).
interface bus_arbiter_rr_if
  import bus_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) ();

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, sel, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, sel, grant_valid, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [SEL_W-1:0] winner_idx,
  output logic             any
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rot_oh;
  logic [SEL_W-1:0] rot_idx;
  logic [SEL_W:0]   idx_sum;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot     = N_REQ'({req, req} >> ptr);
    rot_oh  = '0;
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_oh    = '0;
        rot_oh[i] = 1'b1;
        rot_idx   = SEL_W'(i);
      end
    end
    winner  = N_REQ'(({rot_oh, rot_oh} << ptr) >> N_REQ);
    idx_sum = {1'b0, rot_idx} + {1'b0, ptr};
    if (idx_sum >= N_EXT) begin
      idx_sum = idx_sum - N_EXT;
    end
    winner_idx = SEL_W'(idx_sum);
    any        = |req;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the shared CPU bus: registered one-hot grant,
// encoded mux select and a forced release after MAX_HOLD owned cycles.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             clr,
  bus_arbiter_rr_if.slave  bus
);

  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;

  logic [N_REQ-1:0] pick_oh;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             limit_hit;
  logic             release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // While owning, sel_q is the owner's index, so it addresses its own request.
  assign owner_req   = bus.req[sel_q];
  assign limit_hit   = (hold_cnt == HOLD_LAST);
  assign release_now = bus.done | ~owner_req | limit_hit;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      grant_q   <= grant_nxt;
      sel_q     <= sel_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_any)    state_nxt = ST_OWN;
      ST_OWN:  if (release_now) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Releasing always passes through IDLE with grant cleared, so two drivers
  // never share the bus on back-to-back cycles.
  always_comb begin
    grant_nxt   = grant_q;
    sel_nxt     = sel_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    case (state)
      ST_IDLE: begin
        hold_nxt = '0;
        if (pick_any) begin
          grant_nxt = pick_oh;
          sel_nxt   = pick_idx;
          valid_nxt = 1'b1;
        end else begin
          grant_nxt = '0;
          sel_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      ST_OWN: begin
        if (release_now) begin
          grant_nxt   = '0;
          sel_nxt     = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = '0;
          timeout_nxt = limit_hit & ~bus.done & owner_req;
          ptr_nxt     = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        grant_nxt = '0;
        sel_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.sel         = sel_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scenarios plus a random soak for bus_arbiter_rr, checked against
// an owner/pointer/hold-count model of the arbitration rules.
module tb_bus_arbiter_rr;

  localparam int N        = 32;
  localparam int MAX_HOLD = 16;

  logic clk;
  logic clr;
  int   compared;
  int   mismatched;

  int   mOwner;
  int   mPtr;
  int   mHold;
  bit   mTimeout;

  bus_arbiter_rr_if #(.N_REQ(32), .SEL_W(5)) bus ();

  bus_arbiter_rr #(
    .N_REQ    (32),
    .SEL_W    (5),
    .MAX_HOLD (16)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge of the arbitration rules: who owns the bus afterwards.
  function automatic void modelStep(input logic clrV, input logic [31:0] reqV, input logic doneV);
    bit found;
    bit releasing;
    mTimeout = 1'b0;
    if (clrV) begin
      mOwner = -1;
      mPtr   = 0;
      mHold  = 0;
    end else if (mOwner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && reqV[(mPtr + k) % N]) begin
          found  = 1'b1;
          mOwner = (mPtr + k) % N;
          mHold  = 0;
        end
      end
    end else begin
      releasing = doneV || !reqV[mOwner] || (mHold == MAX_HOLD - 1);
      if (releasing) begin
        mTimeout = !doneV && reqV[mOwner];
        mPtr     = (mOwner + 1) % N;
        mOwner   = -1;
        mHold    = 0;
      end else begin
        mHold = mHold + 1;
      end
    end
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expGrant;
    logic [31:0] expSel;
    expGrant = (mOwner < 0) ? 32'h0 : (32'(1) << mOwner);
    expSel   = (mOwner < 0) ? 32'h0 : 32'(mOwner);
    checkValue({tag, ".grant"},   bus.grant, expGrant);
    checkValue({tag, ".sel"},     {27'h0, bus.sel}, expSel);
    checkValue({tag, ".valid"},   {31'h0, bus.grant_valid}, {31'h0, mOwner >= 0});
    checkValue({tag, ".timeout"}, {31'h0, bus.timeout}, {31'h0, mTimeout});
  endtask

  task automatic applyStimulus(input logic clrV, input logic [31:0] reqV, input logic doneV, input string tag);
    clr      = clrV;
    bus.req  = reqV;
    bus.done = doneV;
    @(posedge clk);
    modelStep(clrV, reqV, doneV);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int          rotExp[4];
    logic [31:0] curReq;
    logic        clrV;
    logic        doneV;

    rotExp     = '{1, 9, 20, 1};
    compared   = 0;
    mismatched = 0;
    mOwner     = -1;
    mPtr       = 0;
    mHold      = 0;
    mTimeout   = 1'b0;
    clr        = 1'b1;
    bus.req    = '0;
    bus.done   = 1'b0;

    $display("[TB] reset with all requests high");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, "rst0");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, "rst1");
    checkValue("rst_grant", bus.grant, 32'h0);
    checkValue("rst_valid", {31'h0, bus.grant_valid}, 32'h0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, "rst_rel");
    checkValue("rel_grant", bus.grant, 32'h1);
    checkValue("rel_sel",   {27'h0, bus.sel}, 32'h0);
    checkValue("rel_valid", {31'h0, bus.grant_valid}, 32'h1);

    $display("[TB] rotation over bits 1, 9, 20");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0010_0202, 1'b0, "rot_own1");
      checkValue("rot_sel", {27'h0, bus.sel}, 32'(rotExp[k]));
      applyStimulus(1'b0, 32'h0010_0202, 1'b0, "rot_own2");
      applyStimulus(1'b0, 32'h0010_0202, 1'b1, "rot_done");
      checkValue("rot_gap", bus.grant, 32'h0);
    end

    $display("[TB] pointer wrap from 31 to 0");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    applyStimulus(1'b0, 32'h4000_0000, 1'b0, "wrap_b30");
    applyStimulus(1'b0, 32'h4000_0000, 1'b1, "wrap_b30_done");
    applyStimulus(1'b0, 32'h8000_0001, 1'b0, "wrap_first");
    checkValue("wrap_sel31", {27'h0, bus.sel}, 32'd31);
    applyStimulus(1'b0, 32'h8000_0001, 1'b1, "wrap_done");
    applyStimulus(1'b0, 32'h8000_0001, 1'b0, "wrap_second");
    checkValue("wrap_sel0", {27'h0, bus.sel}, 32'd0);

    $display("[TB] hold limit timeout");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b0, 32'h8, 1'b0, "to_own");
      checkValue("to_hold_grant", bus.grant, 32'h8);
    end
    applyStimulus(1'b0, 32'h8, 1'b0, "to_release");
    checkValue("to_pulse", {31'h0, bus.timeout}, 32'h1);
    checkValue("to_gap", bus.grant, 32'h0);
    applyStimulus(1'b0, 32'h8, 1'b0, "to_regrant");
    checkValue("to_regrant_sel", {27'h0, bus.sel}, 32'd3);
    checkValue("to_pulse_end", {31'h0, bus.timeout}, 32'h0);

    $display("[TB] done on the last hold cycle, then request drop");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    applyStimulus(1'b0, 32'h8, 1'b0, "co_grant");
    for (int c = 0; c < 15; c++) begin
      applyStimulus(1'b0, 32'h8, 1'b0, "co_own");
    end
    applyStimulus(1'b0, 32'h8, 1'b1, "co_done");
    checkValue("co_no_pulse", {31'h0, bus.timeout}, 32'h0);
    checkValue("co_gap", bus.grant, 32'h0);
    applyStimulus(1'b0, 32'h8, 1'b0, "drop_grant");
    applyStimulus(1'b0, 32'h8, 1'b0, "drop_own");
    applyStimulus(1'b0, 32'h0, 1'b0, "drop_release");
    checkValue("drop_gap", bus.grant, 32'h0);
    checkValue("drop_no_pulse", {31'h0, bus.timeout}, 32'h0);

    $display("[TB] reset in the middle of ownership");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    applyStimulus(1'b0, 32'h4, 1'b0, "mr_b2");
    applyStimulus(1'b0, 32'h4, 1'b1, "mr_b2_done");
    applyStimulus(1'b0, 32'h14, 1'b0, "mr_own1");
    checkValue("mr_owner4", {27'h0, bus.sel}, 32'd4);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 32'h14, 1'b0, "mr_own");
    end
    applyStimulus(1'b1, 32'h14, 1'b0, "mr_clr");
    checkValue("mr_clr_grant", bus.grant, 32'h0);
    checkValue("mr_clr_pulse", {31'h0, bus.timeout}, 32'h0);
    applyStimulus(1'b0, 32'h14, 1'b0, "mr_after");
    checkValue("mr_after_sel", {27'h0, bus.sel}, 32'd2);

    $display("[TB] random soak");
    applyStimulus(1'b1, 32'h0, 1'b0, "rst");
    curReq = 32'h0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        curReq = $urandom & $urandom & $urandom;
      end
      clrV  = ($urandom_range(0, 99) == 0);
      doneV = ($urandom_range(0, 9) == 0);
      applyStimulus(clrV, curReq, doneV, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
